pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
// - Parametrised iCE40 PLL wrapper plus lock supervisor and reset sequencer.
// - Holds the PLL in reset, qualifies LOCK as stable, then releases NUM_RESETS
//   downstream resets in order, one at a time.
// - Detects loss of lock, re-asserts all resets and retries the PLL.
//   Latches a fault once the retry budget is spent.
// - Sits at the top of each board design, between the board oscillator and all
//   clocked logic.
// PARAMETERS
// - DIVR 0; DIVF 40; DIVQ 4; FILTER_RANGE 2: PLL divider settings, passed straight through.
// - LOCK_STABLE_CYCLES 1024: cycles that synced LOCK must stay high before release.
// - LOCK_TIMEOUT_CYCLES 65536: cycles to wait for LOCK before counting a failed attempt.
// - PLL_RESET_CYCLES 16: cycles RESETB is held low per attempt.
// - MAX_RETRIES 3: failed attempts allowed before fault; 0 means one attempt only.
// - NUM_RESETS 2: number of staggered reset outputs.
// - STAGGER_CYCLES 16: cycles between successive reset deassertions.
// PORTS
// - clock_in         in   1          reference clock; every register is clocked by it.
// - reset            in   1          synchronous, active-high.
// - clock_out        out  1          PLL output clock (PLLOUTCORE).
// - locked           out  1          qualified lock; high only in RUN.
// - rst_out          out  NUM_RESETS active-high resets in the clock_in domain; consumers resynchronise.
// - fault            out  1          retries exhausted; sticky until reset.
// - lock_lost_count  out  8          saturating count of lock losses seen in RUN.
// - attempt          out  4          current attempt number, zero-based.
// BEHAVIOUR
// - Raw PLL LOCK passes through a 2-flop synchroniser (lock_s). All latencies are from lock_s.
// - While reset=1: PLL RESETB=0; rst_out all 1; locked=0; fault=0; lock_lost_count=0;
//   attempt=0; state=PLL_RST; counters cleared.
// - Reset mid-operation returns to exactly these values on the next edge.
// - FSM states: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
// - PLL_RST: RESETB=0 for PLL_RESET_CYCLES cycles, then go to WAIT_LOCK with RESETB=1.
// - WAIT_LOCK:
//   - lock_s=1 -> STABLE, counter cleared.
//   - After LOCK_TIMEOUT_CYCLES cycles with lock_s=0:
//     if attempt==MAX_RETRIES -> FAULT; else attempt++ and go to PLL_RST.
// - STABLE:
//   - lock_s=0 at any cycle -> WAIT_LOCK. The timeout counter restarts; attempt is unchanged.
//   - LOCK_STABLE_CYCLES consecutive cycles of lock_s=1 -> RELEASE.
// - RELEASE:
//   - rst_out[0] deasserts on entry; rst_out[i] deasserts STAGGER_CYCLES after rst_out[i-1].
//   - One cycle after the last bit deasserts -> RUN.
//   - lock_s=0 here -> all rst_out=1 in the same cycle, then go to PLL_RST.
//     This counts as a lock loss only if the current state is RUN.
// - RUN:
//   - locked=1.
//   - lock_s=0 -> in the same clock edge: locked=0, all rst_out=1,
//     lock_lost_count++ (saturates at 255), attempt=0, then go to PLL_RST.
// - FAULT: RESETB=0, rst_out all 1, fault=1; leave only via reset.
// - Counter widths: $clog2(max(parameter)+1).
// - rst_out, locked and fault are registered outputs; no combinational path from the LOCK pin.
// STRUCTURE
// - Shared package pll_pkg: FSM state enum; default divider constants; lock-loss
//   counter width (8).
// - Sub-module ice40_pll_core: parametrised SB_PLL40_CORE instance (SIMPLE feedback,
//   BYPASS=0) exposing resetb, clock_out and lock.
// - Supervisor FSM, synchroniser and counters live in this module.
// TESTING
// All tests use a behavioural PLL stub with controllable LOCK and these parameters:
// LOCK_STABLE=8, TIMEOUT=32, PLL_RESET=4, MAX_RETRIES=2, NUM_RESETS=3, STAGGER=2.
// 1. Clean start: LOCK rises 10 cycles after RESETB=1.
//    -> rst_out releases bit0, then bit1 after +2, then bit2 after +2;
//       locked=1 one cycle after bit2; fault=0.
// 2. Glitch in STABLE: LOCK drops for 1 cycle after 5 stable cycles.
//    -> stability count restarts; release happens 8 cycles after LOCK returns
//       (plus synchroniser delay).
// 3. Loss in RUN: LOCK=0 for 1 cycle.
//    -> all rst_out=1 and locked=0 on the next edge; lock_lost_count=1;
//       RESETB low for 4 cycles; full re-sequence follows.
// 4. Never locks.
//    -> 3 attempts of 4+32 cycles each; attempt goes 0,1,2; fault=1;
//       RESETB stays 0; rst_out all 1.
// 5. reset pulsed in RELEASE after rst_out[0] has released.
//    -> next edge: all rst_out=1, locked=0, counters 0, state PLL_RST.
// 6. Drive 300 lock losses.
//    -> lock_lost_count saturates at 255 with no wrap.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
package pll_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAULT
  } pll_state_e;

  localparam int unsigned DEF_DIVR         = 0;
  localparam int unsigned DEF_DIVF         = 40;
  localparam int unsigned DEF_DIVQ         = 4;
  localparam int unsigned DEF_FILTER_RANGE = 2;

  localparam int unsigned LOST_CNT_W = 8;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ice40_pll_core.sv
// iCE40 SB_PLL40_CORE in SIMPLE feedback mode; simulation builds get a
// behavioural stand-in whose LOCK rises a short while after RESETB goes high.
module ice40_pll_core #(
  parameter int unsigned DIVR         = 0,
  parameter int unsigned DIVF         = 40,
  parameter int unsigned DIVQ         = 4,
  parameter int unsigned FILTER_RANGE = 2
) (
  input  logic clock_in,
  input  logic resetb,
  output logic clock_out,
  output logic lock
);

`ifdef SYNTHESIS
  SB_PLL40_CORE #(
    .FEEDBACK_PATH("SIMPLE"),
    .DIVR(4'(DIVR)),
    .DIVF(7'(DIVF)),
    .DIVQ(3'(DIVQ)),
    .FILTER_RANGE(3'(FILTER_RANGE))
  ) u_sb_pll (
    .REFERENCECLK(clock_in),
    .PLLOUTCORE(clock_out),
    .PLLOUTGLOBAL(),
    .EXTFEEDBACK(1'b0),
    .DYNAMICDELAY(8'h00),
    .LOCK(lock),
    .BYPASS(1'b0),
    .RESETB(resetb),
    .LATCHINPUTVALUE(1'b0),
    .SDO(),
    .SDI(1'b0),
    .SCLK(1'b0)
  );
`else
  // Rough settling time that grows with the feedback ratio and loop filter.
  localparam int unsigned SETTLE_CYCLES = ((DIVF + 1) >> DIVQ) + DIVR + FILTER_RANGE + 1;

  logic [7:0] settle;

  assign clock_out = clock_in;

  always_ff @(posedge clock_in) begin
    if (!resetb) begin
      settle <= '0;
      lock   <= 1'b0;
    end else if (settle == 8'(SETTLE_CYCLES)) begin
      lock <= 1'b1;
    end else begin
      settle <= settle + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL wrapper with lock qualification, staggered reset release and retry/fault handling.
//   state     | meaning
//   PLL_RST   | PLL RESETB held low for PLL_RESET_CYCLES
//   WAIT_LOCK | RESETB high, waiting for synced lock (timeout -> retry or fault)
//   STABLE    | lock seen, must hold for LOCK_STABLE_CYCLES
//   RELEASE   | rst_out bits released one by one, STAGGER_CYCLES apart
//   RUN       | all resets released, locked=1
//   FAULT     | retries exhausted; only reset leaves
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int unsigned DIVR                = DEF_DIVR,
  parameter int unsigned DIVF                = DEF_DIVF,
  parameter int unsigned DIVQ                = DEF_DIVQ,
  parameter int unsigned FILTER_RANGE        = DEF_FILTER_RANGE,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned PLL_RESET_CYCLES    = 16,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned NUM_RESETS          = 2,
  parameter int unsigned STAGGER_CYCLES      = 16
) (
  input  logic                  clock_in,
  input  logic                  reset,
  output logic                  clock_out,
  output logic                  locked,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic                  fault,
  output logic [LOST_CNT_W-1:0] lock_lost_count,
  output logic [3:0]            attempt
);

  localparam int unsigned TMR_MAX = max4(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         PLL_RESET_CYCLES, STAGGER_CYCLES);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] LD_RST     = TMR_W'(PLL_RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_TIMEOUT = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_STABLE  = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_STAGGER = TMR_W'(STAGGER_CYCLES - 1);

  logic             pll_resetb;
  logic             pll_lock;
  logic             lock_meta;
  logic             lock_s;
  pll_state_e       state;
  logic [TMR_W-1:0] timer;

  ice40_pll_core #(
    .DIVR(DIVR),
    .DIVF(DIVF),
    .DIVQ(DIVQ),
    .FILTER_RANGE(FILTER_RANGE)
  ) u_pll (
    .clock_in(clock_in),
    .resetb(pll_resetb),
    .clock_out(clock_out),
    .lock(pll_lock)
  );

  always_ff @(posedge clock_in) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state           <= PLL_RST;
      timer           <= LD_RST;
      pll_resetb      <= 1'b0;
      rst_out         <= '1;
      locked          <= 1'b0;
      fault           <= 1'b0;
      lock_lost_count <= '0;
      attempt         <= '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (timer == '0) begin
            state      <= WAIT_LOCK;
            pll_resetb <= 1'b1;
            timer      <= LD_TIMEOUT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            timer <= LD_STABLE;
          end else if (timer == '0) begin
            pll_resetb <= 1'b0;
            if (attempt == 4'(MAX_RETRIES)) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state   <= PLL_RST;
              attempt <= attempt + 1'b1;
              timer   <= LD_RST;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            timer <= LD_TIMEOUT;
          end else if (timer == '0) begin
            state   <= RELEASE;
            rst_out <= rst_out << 1;
            timer   <= LD_STAGGER;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RELEASE: begin
          // Shifting zeros in from bit 0 releases the resets in index order.
          if (!lock_s) begin
            state      <= PLL_RST;
            rst_out    <= '1;
            pll_resetb <= 1'b0;
            timer      <= LD_RST;
          end else if (rst_out == '0) begin
            state  <= RUN;
            locked <= 1'b1;
          end else if (timer == '0) begin
            rst_out <= rst_out << 1;
            timer   <= LD_STAGGER;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state      <= PLL_RST;
            locked     <= 1'b0;
            rst_out    <= '1;
            pll_resetb <= 1'b0;
            attempt    <= '0;
            timer      <= LD_RST;
            if (lock_lost_count != '1) lock_lost_count <= lock_lost_count + 1'b1;
          end
        end
        FAULT: begin
          pll_resetb <= 1'b0;
          rst_out    <= '1;
          fault      <= 1'b1;
        end
        default: begin
          state      <= PLL_RST;
          pll_resetb <= 1'b0;
          rst_out    <= '1;
          locked     <= 1'b0;
          timer      <= LD_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random LOCK patterns,
// checked every cycle against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int LS = 8, TO = 32, PR = 4, MR = 2, NR = 3, ST = 2;
  localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_REL = 3, PH_RUN = 4, PH_FLT = 5;

  logic          clock_in = 1'b0;
  logic          reset    = 1'b1;
  logic          lock_pin = 1'b0;
  logic          clock_out, locked, fault;
  logic [NR-1:0] rst_out;
  logic [7:0]    lock_lost_count;
  logic [3:0]    attempt;

  int checks = 0, failures = 0, cyc = 0;
  int m_ph, m_t, m_att, m_lost;
  bit m_fault, s1, s2;
  int g, t0, t1, t2, tl, n, cnt, start, ta1, ta2, tf, len;
  logic lk, rr;

  pll_lock_supervisor #(
    .DIVR(0), .DIVF(40), .DIVQ(4), .FILTER_RANGE(2),
    .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT_CYCLES(TO), .PLL_RESET_CYCLES(PR),
    .MAX_RETRIES(MR), .NUM_RESETS(NR), .STAGGER_CYCLES(ST)
  ) dut (
    .clock_in(clock_in),
    .reset(reset),
    .clock_out(clock_out),
    .locked(locked),
    .rst_out(rst_out),
    .fault(fault),
    .lock_lost_count(lock_lost_count),
    .attempt(attempt)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: phase plus cycles elapsed in it; outputs derived from those.
  task automatic model_step(input logic lkv, input logic rsv);
    bit ls;
    ls = s2;
    if (rsv) begin
      m_ph = PH_RST; m_t = 0; m_att = 0; m_lost = 0; m_fault = 0; s1 = 0; s2 = 0;
    end else begin
      s2 = s1;
      s1 = lkv;
      case (m_ph)
        PH_RST:  if (m_t + 1 >= PR) begin m_ph = PH_WAIT; m_t = 0; end else m_t++;
        PH_WAIT: if (ls) begin m_ph = PH_STAB; m_t = 0; end
                 else if (m_t + 1 >= TO) begin
                   if (m_att == MR) begin m_ph = PH_FLT; m_fault = 1; end
                   else begin m_att++; m_ph = PH_RST; m_t = 0; end
                 end else m_t++;
        PH_STAB: if (!ls) begin m_ph = PH_WAIT; m_t = 0; end
                 else if (m_t + 1 >= LS) begin m_ph = PH_REL; m_t = 0; end
                 else m_t++;
        PH_REL:  if (!ls) begin m_ph = PH_RST; m_t = 0; end
                 else if (m_t >= (NR - 1) * ST) begin m_ph = PH_RUN; m_t = 0; end
                 else m_t++;
        PH_RUN:  if (!ls) begin
                   m_ph = PH_RST; m_t = 0; m_att = 0;
                   if (m_lost < 255) m_lost++;
                 end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [NR-1:0] er;
    for (int i = 0; i < NR; i++)
      er[i] = !((m_ph == PH_REL && m_t >= i * ST) || m_ph == PH_RUN);
    chk("rst_out", 32'(rst_out), 32'(er));
    chk("locked", 32'(locked), 32'(m_ph == PH_RUN));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("lock_lost_count", 32'(lock_lost_count), 32'(m_lost));
    chk("attempt", 32'(attempt), 32'(m_att));
    chk("pll_resetb", 32'(dut.pll_resetb), 32'(!(m_ph == PH_RST || m_ph == PH_FLT)));
    if (m_ph == PH_RST) chk("state_pll_rst", 32'(dut.state == pll_pkg::PLL_RST), 32'd1);
  endtask

  task automatic tick(input logic lkv, input logic rsv);
    lock_pin = lkv;
    reset    = rsv;
    force dut.pll_lock = lock_pin;
    @(posedge clock_in);
    model_step(lkv, rsv);
    cyc++;
    #1;
    compare_all();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    force dut.pll_lock = lock_pin;
    m_ph = PH_RST; m_t = 0; m_att = 0; m_lost = 0; m_fault = 0; s1 = 0; s2 = 0;

    // Reset state
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("reset_rst_out", 32'(rst_out), 32'h7);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_resetb", 32'(dut.pll_resetb), 32'd0);

    // 1: clean start, LOCK 10 cycles after RESETB rises
    n = 0;
    while (dut.pll_resetb !== 1'b1 && n < 20) begin tick(1'b0, 1'b0); n++; end
    chk("t1_resetb_up", 32'(dut.pll_resetb), 32'd1);
    repeat (10) tick(1'b0, 1'b0);
    g = cyc + 1;
    t0 = -1; t1 = -1; t2 = -1; tl = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0);
      if (t0 < 0 && rst_out[0] === 1'b0) t0 = cyc;
      if (t1 < 0 && rst_out[1] === 1'b0) t1 = cyc;
      if (t2 < 0 && rst_out[2] === 1'b0) t2 = cyc;
      if (tl < 0 && locked === 1'b1) tl = cyc;
    end
    chk("t1_release_latency", 32'(t0 - g), 32'd10);
    chk("t1_stagger_bit1", 32'(t1 - t0), 32'd2);
    chk("t1_stagger_bit2", 32'(t2 - t1), 32'd2);
    chk("t1_locked_after_bit2", 32'(tl - t2), 32'd1);
    chk("t1_fault", 32'(fault), 32'd0);

    // 3: one-cycle loss in RUN
    tick(1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0);
      if (dut.pll_resetb === 1'b0) cnt++;
    end
    chk("t3_resetb_low_cycles", 32'(cnt), 32'd4);
    chk("t3_lost_count", 32'(lock_lost_count), 32'd1);
    chk("t3_relocked", 32'(locked), 32'd1);

    // 2: one-cycle glitch after 5 stable cycles
    tick(1'b1, 1'b1);
    n = 0;
    while (m_ph != PH_WAIT && n < 20) begin tick(1'b0, 1'b0); n++; end
    repeat (7) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("t2_not_released", 32'(rst_out), 32'h7);
    g = cyc + 1;
    t0 = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1, 1'b0);
      if (t0 < 0 && rst_out[0] === 1'b0) t0 = cyc;
    end
    chk("t2_release_latency", 32'(t0 - g), 32'd10);

    // 5: reset pulse in RELEASE after bit0 released
    tick(1'b1, 1'b1);
    n = 0;
    while (!(m_ph == PH_REL && m_t >= 1) && n < 40) begin tick(1'b1, 1'b0); n++; end
    chk("t5_bit0_released", 32'(rst_out[0]), 32'd0);
    tick(1'b1, 1'b1);
    chk("t5_rst_out", 32'(rst_out), 32'h7);
    chk("t5_locked", 32'(locked), 32'd0);
    chk("t5_attempt", 32'(attempt), 32'd0);
    chk("t5_state", 32'(dut.state == pll_pkg::PLL_RST), 32'd1);

    // 4: never locks
    tick(1'b0, 1'b1);
    start = cyc; ta1 = -1; ta2 = -1; tf = -1;
    for (int i = 0; i < 130; i++) begin
      tick(1'b0, 1'b0);
      if (ta1 < 0 && attempt === 4'd1) ta1 = cyc;
      if (ta2 < 0 && attempt === 4'd2) ta2 = cyc;
      if (tf < 0 && fault === 1'b1) tf = cyc;
    end
    chk("t4_attempt1_at", 32'(ta1 - start), 32'd36);
    chk("t4_attempt2_at", 32'(ta2 - start), 32'd72);
    chk("t4_fault_at", 32'(tf - start), 32'd108);
    repeat (20) tick(1'b1, 1'b0);
    chk("t4_fault_sticky", 32'(fault), 32'd1);
    chk("t4_rst_out", 32'(rst_out), 32'h7);
    chk("t4_resetb", 32'(dut.pll_resetb), 32'd0);

    // 6: 300 lock losses saturate the counter
    tick(1'b1, 1'b1);
    for (int k = 0; k < 300; k++) begin
      n = 0;
      while (m_ph != PH_RUN && n < 100) begin tick(1'b1, 1'b0); n++; end
      if (m_ph != PH_RUN) begin
        chk("t6_run_reached", 32'd0, 32'd1);
        break;
      end
      tick(1'b0, 1'b0);
      repeat (3) tick(1'b1, 1'b0);
    end
    chk("t6_lost_saturated", 32'(lock_lost_count), 32'd255);

    // Random LOCK runs with occasional reset
    tick(1'b1, 1'b1);
    for (int s = 0; s < 150; s++) begin
      lk  = ($urandom_range(0, 9) < 7);
      len = $urandom_range(1, 30);
      for (int j = 0; j < len; j++) begin
        rr = ($urandom_range(0, 199) == 0);
        tick(lk, rr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
